// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: 2-bit history counter encodings
// and the saturating counter step used when training an entry.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_e;

    localparam ctr_e CTR_RESET = WNT;
    localparam ctr_e CTR_ALLOC = WT;

    function automatic ctr_e ctrNext(input ctr_e ctr, input logic taken);
        if (taken) begin
            return (ctr == ST) ? ST : ctr_e'(ctr + 2'd1);
        end
        return (ctr == SNT) ? SNT : ctr_e'(ctr - 2'd1);
    endfunction

endpackage

// File: rtl/btb_pred_pipe.sv
// Two-bit prediction register between pipeline stages.
// Flush wins over stall, so a flushed stage never keeps stale prediction bits.
module btb_pred_pipe (
    input  logic       clk,
    input  logic       rst,
    input  logic       stall,
    input  logic       flush,
    input  logic [1:0] d,
    output logic [1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= 2'b00;
        end else if (flush) begin
            q <= 2'b00;
        end else if (!stall) begin
            q <= d;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry 2-bit history counters: combinational lookup
// in IF, training from the resolved conditional branch in EX, branch/mispredict counters.
import branch_predictor_pkg::*;

module branch_predictor #(
    parameter int IDX_BITS = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        StallE,
    input  logic        FlushE,
    input  logic        BrInstE,
    input  logic        BranchE,
    input  logic [31:0] PCE,
    input  logic [31:0] BranchTarget,
    output logic        isBtbTaken,
    output logic        isBhtTaken,
    output logic [31:0] BtbPCPred,
    output logic        isBtbTakenE,
    output logic        isBhtTakenE,
    output logic [31:0] BranchCnt,
    output logic [31:0] MispredCnt
);

    localparam int ENTRIES  = 1 << IDX_BITS;
    localparam int TAG_BITS = 30 - IDX_BITS;

    logic                validQ  [ENTRIES];
    logic [TAG_BITS-1:0] tagQ    [ENTRIES];
    logic [31:0]         targetQ [ENTRIES];
    ctr_e                ctrQ    [ENTRIES];

    logic [IDX_BITS-1:0] idxF, idxE;
    logic [TAG_BITS-1:0] tagF, tagE;
    logic                hitF, hitE;
    logic [1:0]          predD, predE;
    logic                unusedPcBits;

    assign idxF = PCF[IDX_BITS+1:2];
    assign tagF = PCF[31:IDX_BITS+2];
    assign idxE = PCE[IDX_BITS+1:2];
    assign tagE = PCE[31:IDX_BITS+2];
    assign unusedPcBits = ^{PCF[1:0], PCE[1:0]};

    assign hitF = validQ[idxF] && (tagQ[idxF] == tagF);
    assign hitE = validQ[idxE] && (tagQ[idxE] == tagE);

    always_comb begin
        isBtbTaken = hitF;
        isBhtTaken = hitF && ctrQ[idxF][1];
        BtbPCPred  = hitF ? targetQ[idxF] : 32'd0;
    end

    // Valid and counters are reset; a reset cycle writes no entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                validQ[i] <= 1'b0;
                ctrQ[i]   <= CTR_RESET;
            end
        end else if (BrInstE) begin
            if (hitE) begin
                ctrQ[idxE] <= ctrNext(ctrQ[idxE], BranchE);
            end else if (BranchE) begin
                validQ[idxE] <= 1'b1;
                ctrQ[idxE]   <= CTR_ALLOC;
            end
        end
    end

    // Tag rewrite on a hit stores the same value, so taken branches always write both.
    always_ff @(posedge clk) begin
        if (!rst && BrInstE && BranchE) begin
            tagQ[idxE]    <= tagE;
            targetQ[idxE] <= BranchTarget;
        end
    end

    btb_pred_pipe uPipeD (
        .clk   (clk),
        .rst   (rst),
        .stall (StallD),
        .flush (FlushD),
        .d     ({isBtbTaken, isBhtTaken}),
        .q     (predD)
    );

    btb_pred_pipe uPipeE (
        .clk   (clk),
        .rst   (rst),
        .stall (StallE),
        .flush (FlushE),
        .d     (predD),
        .q     (predE)
    );

    assign isBtbTakenE = predE[1];
    assign isBhtTakenE = predE[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            BranchCnt  <= 32'd0;
            MispredCnt <= 32'd0;
        end else if (BrInstE) begin
            BranchCnt <= BranchCnt + 32'd1;
            if (isBhtTakenE != BranchE) begin
                MispredCnt <= MispredCnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: a behavioural BTB model predicts every
// output each cycle; expectations are queued at drive time and popped when sampled.
module tb_branch_predictor;

    localparam int W = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PCF;
    logic        StallD, FlushD, StallE, FlushE;
    logic        BrInstE, BranchE;
    logic [31:0] PCE, BranchTarget;
    logic        isBtbTaken, isBhtTaken;
    logic [31:0] BtbPCPred;
    logic        isBtbTakenE, isBhtTakenE;
    logic [31:0] BranchCnt, MispredCnt;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] expQ[$];

    // Reference model state
    logic        mValid  [64];
    logic [23:0] mTag    [64];
    logic [31:0] mTarget [64];
    logic [1:0]  mCtr    [64];
    logic [1:0]  mPipeD, mPipeE;
    logic [31:0] mBranchCnt, mMispredCnt;

    logic [31:0] pcPool [6];

    branch_predictor #(.IDX_BITS(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .PCF          (PCF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .StallE       (StallE),
        .FlushE       (FlushE),
        .BrInstE      (BrInstE),
        .BranchE      (BranchE),
        .PCE          (PCE),
        .BranchTarget (BranchTarget),
        .isBtbTaken   (isBtbTaken),
        .isBhtTaken   (isBhtTaken),
        .BtbPCPred    (BtbPCPred),
        .isBtbTakenE  (isBtbTakenE),
        .isBhtTakenE  (isBhtTakenE),
        .BranchCnt    (BranchCnt),
        .MispredCnt   (MispredCnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, queue the model's expectation, compare at
    // the falling edge, then advance the model across the rising edge.
    task automatic step(input logic r, input logic [31:0] pcf,
                        input logic sD, input logic fD, input logic sE, input logic fE,
                        input logic bi, input logic b,
                        input logic [31:0] pce, input logic [31:0] tgt);
        logic [5:0]   fi, ei;
        logic         fh, fb, eh;
        logic [W-1:0] e;
        rst = r; PCF = pcf; StallD = sD; FlushD = fD; StallE = sE; FlushE = fE;
        BrInstE = bi; BranchE = b; PCE = pce; BranchTarget = tgt;

        fi = pcf[7:2];
        ei = pce[7:2];
        fh = mValid[fi] && (mTag[fi] == pcf[31:8]);
        fb = fh && mCtr[fi][1];
        eh = mValid[ei] && (mTag[ei] == pce[31:8]);

        if (!r) expQ.push_back({fh, fb, fh ? mTarget[fi] : 32'd0,
                                mPipeE, mBranchCnt, mMispredCnt});

        @(negedge clk);
        if (!r) begin
            e = expQ.pop_front();
            check("isBtbTaken",  {31'd0, isBtbTaken},  {31'd0, e[99]});
            check("isBhtTaken",  {31'd0, isBhtTaken},  {31'd0, e[98]});
            check("BtbPCPred",   BtbPCPred,            e[97:66]);
            check("isBtbTakenE", {31'd0, isBtbTakenE}, {31'd0, e[65]});
            check("isBhtTakenE", {31'd0, isBhtTakenE}, {31'd0, e[64]});
            check("BranchCnt",   BranchCnt,            e[63:32]);
            check("MispredCnt",  MispredCnt,           e[31:0]);
        end

        if (r) begin
            for (int i = 0; i < 64; i++) begin
                mValid[i] = 1'b0;
                mCtr[i]   = 2'b01;
            end
            mPipeD = 2'b00; mPipeE = 2'b00;
            mBranchCnt = 32'd0; mMispredCnt = 32'd0;
        end else begin
            if (bi) begin
                mBranchCnt++;
                if (mPipeE[0] != b) mMispredCnt++;
                if (eh && b) begin
                    if (mCtr[ei] != 2'b11) mCtr[ei] = mCtr[ei] + 2'd1;
                    mTarget[ei] = tgt;
                end else if (eh) begin
                    if (mCtr[ei] != 2'b00) mCtr[ei] = mCtr[ei] - 2'd1;
                end else if (b) begin
                    mValid[ei] = 1'b1; mTag[ei] = pce[31:8];
                    mTarget[ei] = tgt; mCtr[ei] = 2'b10;
                end
            end
            if (fE)       mPipeE = 2'b00;
            else if (!sE) mPipeE = mPipeD;
            if (fD)       mPipeD = 2'b00;
            else if (!sD) mPipeD = {fh, fb};
        end

        @(posedge clk);
        #1;
    endtask

    // Shorthand for a plain cycle with no stall/flush.
    task automatic go(input logic [31:0] pcf, input logic bi, input logic b,
                      input logic [31:0] pce, input logic [31:0] tgt);
        step(1'b0, pcf, 1'b0, 1'b0, 1'b0, 1'b0, bi, b, pce, tgt);
    endtask

    initial begin
        pcPool[0] = 32'h0000_0040; pcPool[1] = 32'h0000_0140;
        pcPool[2] = 32'h0000_0080; pcPool[3] = 32'h0000_0044;
        pcPool[4] = 32'h0000_0240; pcPool[5] = 32'h1000_0080;
        for (int i = 0; i < 64; i++) begin
            mValid[i] = 1'b0; mTag[i] = 24'd0; mTarget[i] = 32'd0; mCtr[i] = 2'b01;
        end
        mPipeD = 2'b00; mPipeE = 2'b00; mBranchCnt = 32'd0; mMispredCnt = 32'd0;

        @(posedge clk); #1;
        step(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset state
        go(32'h0000_0010, 1'b0, 1'b0, 32'h0, 32'h0);

        // Allocate then hit
        go(32'h0000_0000, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0100);
        go(32'h0000_0040, 1'b0, 1'b0, 32'h0, 32'h0);

        // Saturation: 3 taken, 2 not-taken, then a not-taken miss
        for (int i = 0; i < 3; i++) go(32'h0000_0040, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0100);
        for (int i = 0; i < 2; i++) go(32'h0000_0040, 1'b1, 1'b0, 32'h0000_0040, 32'h0000_0000);
        go(32'h0000_0040, 1'b1, 1'b0, 32'h0000_0200, 32'h0000_0abc);
        go(32'h0000_0200, 1'b0, 1'b0, 32'h0, 32'h0);
        go(32'h0000_0040, 1'b0, 1'b0, 32'h0, 32'h0);

        // Conflict eviction
        go(32'h0000_0000, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0100);
        go(32'h0000_0000, 1'b1, 1'b1, 32'h0000_0140, 32'h0000_0300);
        go(32'h0000_0040, 1'b0, 1'b0, 32'h0, 32'h0);
        go(32'h0000_0140, 1'b0, 1'b0, 32'h0, 32'h0);

        // Pipeline: stall D once, flush E on a second instance, stall+flush together
        go(32'h0000_0140, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        go(32'h0000_0140, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        go(32'h0000_0000, 1'b0, 1'b0, 32'h0, 32'h0);
        go(32'h0000_0140, 1'b0, 1'b0, 32'h0, 32'h0);
        go(32'h0000_0000, 1'b0, 1'b0, 32'h0, 32'h0);
        go(32'h0000_0000, 1'b1, 1'b0, 32'h0000_0140, 32'h0);
        go(32'h0000_0140, 1'b0, 1'b0, 32'h0, 32'h0);
        step(1'b0, 32'h0000_0140, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        go(32'h0000_0000, 1'b0, 1'b0, 32'h0, 32'h0);

        // Same-cycle lookup and allocate
        go(32'h0000_0080, 1'b1, 1'b1, 32'h0000_0080, 32'h0000_0800);
        go(32'h0000_0080, 1'b0, 1'b0, 32'h0, 32'h0);

        // Reset overrides a concurrent update
        step(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_00c0, 32'h0000_0ccc);
        go(32'h0000_00c0, 1'b0, 1'b0, 32'h0, 32'h0);
        go(32'h0000_0140, 1'b0, 1'b0, 32'h0, 32'h0);

        // Random traffic over a small set of colliding PCs
        for (int n = 0; n < 300; n++) begin
            step(1'b0, pcPool[$urandom_range(5, 0)],
                 ($urandom_range(7, 0) == 0), ($urandom_range(9, 0) == 0),
                 ($urandom_range(7, 0) == 0), ($urandom_range(9, 0) == 0),
                 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                 pcPool[$urandom_range(5, 0)], $urandom);
        end

        if (expQ.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got=%0d entries left expected=0", expQ.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
